// File: rtl/vc_sched_pkg.sv
// Shared widths, types and reset constants for the VC drain scheduler.
package vc_sched_pkg;

    localparam int MAX_CREDITS = 15;

    function automatic int vc_idx_w(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    function automatic int credit_w(input int credits);
        return $clog2(credits + 1);
    endfunction

    // Widest credit counter any legal CREDITS value needs.
    typedef logic [credit_w(MAX_CREDITS)-1:0] credit_t;

    localparam logic RST_OUT_VALID  = 1'b0;
    localparam logic RST_CREDIT_ERR = 1'b0;

endpackage

// File: rtl/vc_drain_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_grant and wraps;
// the first requesting index wins. The pointer itself is held by the caller.
module rr_arbiter
    import vc_sched_pkg::*;
#(
    parameter int NUM_VC = 4,
    localparam int IW = vc_idx_w(NUM_VC)
) (
    input  logic [NUM_VC-1:0] req,
    input  logic [IW-1:0]     last_grant,
    output logic [NUM_VC-1:0] gnt,
    output logic [IW-1:0]     gnt_idx,
    output logic              gnt_valid
);

    int idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_VC; k++) begin
            idx = (int'(last_grant) + k) % NUM_VC;
            if (!gnt_valid && req[idx[IW-1:0]]) begin
                gnt[idx[IW-1:0]] = 1'b1;
                gnt_idx          = idx[IW-1:0];
                gnt_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_drain_scheduler.sv
// Drains per-VC FIFOs onto one link with credit-gated round-robin grants.
// Define VC_SCHED_ERR_EN to add the sticky credit_err overflow flag.
module vc_drain_scheduler
    import vc_sched_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_VC  = 4,
    parameter int CREDITS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sched_en,
    input  logic [NUM_VC-1:0]              fifo_empty,
    input  logic [NUM_VC-1:0][WIDTH-1:0]   fifo_dataout,
    output logic [NUM_VC-1:0]              fifo_rd_en,
    input  logic [NUM_VC-1:0]              credit_return,
`ifdef VC_SCHED_ERR_EN
    output logic                           credit_err,
`endif
    output logic                           out_valid,
    output logic [WIDTH-1:0]               out_data,
    output logic [vc_idx_w(NUM_VC)-1:0]    out_vc
);

    localparam int IW = vc_idx_w(NUM_VC);
    localparam int CW = credit_w(CREDITS);
    localparam logic [CW-1:0] CRED_FULL = CW'(CREDITS);

    logic [CW-1:0]     credit [NUM_VC];
    logic [IW-1:0]     last_grant;
    logic [NUM_VC-1:0] eligible;
    logic [NUM_VC-1:0] at_full;
    logic [NUM_VC-1:0] gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_valid;

    // Reset gates eligibility so no pop strobe escapes while rst is high.
    always_comb begin
        eligible = '0;
        at_full  = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            eligible[i] = !rst && sched_en && !fifo_empty[i] && (credit[i] != '0);
            at_full[i]  = (credit[i] == CRED_FULL);
        end
    end

    rr_arbiter #(
        .NUM_VC(NUM_VC)
    ) u_rr_arbiter (
        .req       (eligible),
        .last_grant(last_grant),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign fifo_rd_en = gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VC; i++) begin
                credit[i] <= CRED_FULL;
            end
            last_grant <= IW'(NUM_VC - 1);
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                case ({credit_return[i], gnt[i]})
                    2'b10: if (!at_full[i]) credit[i] <= credit[i] + CW'(1);
                    2'b01: credit[i] <= credit[i] - CW'(1);
                    default: ;
                endcase
            end
            if (gnt_valid) begin
                last_grant <= gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= RST_OUT_VALID;
            out_data  <= '0;
            out_vc    <= '0;
        end else begin
            out_valid <= gnt_valid;
            if (gnt_valid) begin
                out_data <= fifo_dataout[gnt_idx];
                out_vc   <= gnt_idx;
            end
        end
    end

`ifdef VC_SCHED_ERR_EN
    // A return into an already-full, ungranted counter means the receiver over-credited.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_err <= RST_CREDIT_ERR;
        end else if (|(credit_return & ~gnt & at_full)) begin
            credit_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vc_drain_scheduler.sv
// Directed bench for vc_drain_scheduler: stimulus pushes expected words into a
// queue, a monitor pops and compares them against the registered output.
module tb_vc_drain_scheduler;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sched_en = 1'b0;
    logic [3:0]        fifo_empty = 4'hF;
    logic [3:0][31:0]  fifo_dataout;
    logic [3:0]        fifo_rd_en;
    logic [3:0]        credit_return = 4'h0;
    logic              out_valid;
    logic [31:0]       out_data;
    logic [1:0]        out_vc;
`ifdef VC_SCHED_ERR_EN
    logic              credit_err;
`endif

    typedef struct {
        logic [1:0]  vc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cnt [4] = '{0, 0, 0, 0};
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vc_drain_scheduler #(
        .WIDTH  (32),
        .NUM_VC (4),
        .CREDITS(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sched_en     (sched_en),
        .fifo_empty   (fifo_empty),
        .fifo_dataout (fifo_dataout),
        .fifo_rd_en   (fifo_rd_en),
        .credit_return(credit_return),
`ifdef VC_SCHED_ERR_EN
        .credit_err   (credit_err),
`endif
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_vc       (out_vc)
    );

    // FIFO model: head word encodes VC and how many words that VC has popped.
    function automatic logic [31:0] head(input int vc, input int cnt);
        return 32'hA000_0000 | (32'(vc) << 16) | 32'(cnt);
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fifo_dataout[i] = head(i, pop_cnt[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (fifo_rd_en[i]) pop_cnt[i] <= pop_cnt[i] + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] empty, input logic [3:0] ret,
                        input logic en, input logic [3:0] exp_rd);
        exp_t e;
        @(negedge clk);
        if (rst) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", out_data, 32'd0);
            check("rst_out_vc", 32'(out_vc), 32'd0);
`ifdef VC_SCHED_ERR_EN
            check("rst_credit_err", 32'(credit_err), 32'd0);
`endif
        end
        rst           = r;
        fifo_empty    = empty;
        credit_return = ret;
        sched_en      = en;
        #1;
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        for (int k = 0; k < 4; k++) begin
            if (exp_rd[k]) begin
                e.vc   = 2'(k);
                e.data = head(k, pop_cnt[k]);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 4'hF, 4'h0, 1'b0, 4'h0);
        step(1'b1, 4'hF, 4'h0, 1'b0, 4'h0);
    endtask

    // Latency is exactly one cycle, so every queued word must appear at the next edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_valid", 32'(out_valid), 32'd1);
                check("out_vc", 32'(out_vc), 32'(e.vc));
                check("out_data", out_data, e.data);
            end else if (out_valid) begin
                check("out_valid_idle", 32'(out_valid), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq3 [12];
        // reset holds rd_en low even with requests pending
        step(1'b1, 4'h0, 4'h0, 1'b1, 4'h0);
        step(1'b1, 4'h0, 4'h0, 1'b1, 4'h0);
        // rotation from VC0
        step(1'b0, 4'h0, 4'h0, 1'b1, 4'b0001);
        step(1'b0, 4'h0, 4'h0, 1'b1, 4'b0010);
        step(1'b0, 4'h0, 4'h0, 1'b1, 4'b0100);
        step(1'b0, 4'h0, 4'h0, 1'b1, 4'b1000);
        step(1'b0, 4'h0, 4'h0, 1'b1, 4'b0001);

        // only VC2 non-empty: four grants, then a returned credit grants one cycle later
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 4'b1011, 4'h0, 1'b1, 4'b0100);
        step(1'b0, 4'b1011, 4'h0, 1'b1, 4'h0);
        step(1'b0, 4'b1011, 4'h0, 1'b1, 4'h0);
        step(1'b0, 4'b1011, 4'b0100, 1'b1, 4'h0);
        step(1'b0, 4'b1011, 4'h0, 1'b1, 4'b0100);
        step(1'b0, 4'b1011, 4'h0, 1'b1, 4'h0);

        // VC1 at credit 1 granted with a simultaneous return keeps its credit
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1101, 4'h0, 1'b1, 4'b0010);
        seq3 = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'h0, (i == 3) ? 4'b0010 : 4'h0, 1'b1, seq3[i]);
        end

        // return into a full counter saturates
        do_reset();
        step(1'b0, 4'hF, 4'b1000, 1'b1, 4'h0);
`ifdef VC_SCHED_ERR_EN
        @(posedge clk);
        #2;
        check("credit_err_set", 32'(credit_err), 32'd1);
`endif
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0111, 4'h0, 1'b1, 4'b1000);
        step(1'b0, 4'b0111, 4'h0, 1'b1, 4'h0);
`ifdef VC_SCHED_ERR_EN
        check("credit_err_sticky", 32'(credit_err), 32'd1);
`endif

        // sched_en 1,0,1 with VC0 non-empty
        do_reset();
        step(1'b0, 4'b1110, 4'h0, 1'b1, 4'b0001);
        step(1'b0, 4'b1110, 4'h0, 1'b0, 4'h0);
        step(1'b0, 4'b1110, 4'h0, 1'b1, 4'b0001);
        step(1'b0, 4'b1110, 4'h0, 1'b0, 4'h0);

        // drain all credits, reset right behind a grant, then a full refill is visible
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b0, 4'h0, 4'h0, 1'b1, 4'(1 << (i % 4)));
        step(1'b0, 4'h0, 4'h0, 1'b1, 4'h0);
        step(1'b0, 4'h0, 4'b1000, 1'b1, 4'h0);
        step(1'b0, 4'h0, 4'h0, 1'b1, 4'b1000);
        step(1'b1, 4'h0, 4'h0, 1'b1, 4'h0);
        for (int i = 0; i < 16; i++) step(1'b0, 4'h0, 4'h0, 1'b1, 4'(1 << (i % 4)));
        step(1'b0, 4'h0, 4'h0, 1'b1, 4'h0);

        step(1'b0, 4'hF, 4'h0, 1'b0, 4'h0);
        step(1'b0, 4'hF, 4'h0, 1'b0, 4'h0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
